// File: rtl/clic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clic_pkg
// Description : Shared types, trigger-mode encoding and parameter helpers for
//               the CLIC gateway adapter and its per-source gateways.
// Revision    : 1.0 - initial release
// ============================================================================
package clic_pkg;

    // Widest VS id / VS priority a register-file field can carry
    localparam int MAX_VSID_W   = 8;
    localparam int MAX_VSPRIO_W = 8;

    // clicintattr.trig encoding: bit 0 = edge, bit 1 = negative polarity
    typedef enum logic [1:0] {
        POS_LEVEL = 2'b00,
        POS_EDGE  = 2'b01,
        NEG_LEVEL = 2'b10,
        NEG_EDGE  = 2'b11
    } trig_e;

    typedef struct packed {
        logic [7:0] q;
    } clicint_ctl_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] trig;
        logic       shv;
    } clicint_attr_t;

    typedef struct packed {
        logic q;
    } clicint_ie_t;

    typedef struct packed {
        logic q;
        logic qe;
    } clicint_ip_t;

    typedef struct packed {
        clicint_ctl_t  ctl;
        clicint_attr_t attr;
        clicint_ie_t   ie;
        clicint_ip_t   ip;
    } clicint_reg2hw_t;

    typedef struct packed {
        logic d;
        logic de;
    } clicint_hw2reg_ip_t;

    typedef struct packed {
        clicint_hw2reg_ip_t ip;
    } clicint_hw2reg_t;

    // One source slot inside a clicintv word
    typedef struct packed {
        logic                  v;
        logic [MAX_VSID_W-1:0] vsid;
    } clicintv_field_t;

    typedef struct packed {
        clicintv_field_t [3:0] fld;
    } clicintv_reg2hw_t;

    typedef struct packed {
        logic [3:0][MAX_VSPRIO_W-1:0] prio;
    } clicvs_reg2hw_t;

    function automatic int ceildiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int rounddown(input int a, input int b);
        return (a / b) * b;
    endfunction

    function automatic bit params_legal(
        input int n_source,
        input int intctlbits,
        input int vsid_w,
        input int vsprio_w,
        input int n_vsctxts,
        input int src_per_word
    );
        return (n_source >= 2)
            && (intctlbits >= 0) && (intctlbits <= 8)
            && (vsid_w >= 1) && (vsid_w <= MAX_VSID_W)
            && (vsprio_w >= 1) && (vsprio_w <= MAX_VSPRIO_W)
            && (n_vsctxts >= 4) && ((n_vsctxts % 4) == 0)
            && ((src_per_word == 1) || (src_per_word == 2) || (src_per_word == 4));
    endfunction

endpackage
`default_nettype wire

// File: rtl/clic_gateway.sv
`default_nettype none
// ============================================================================
// Module      : clic_gateway
// Description : Per-source interrupt gateway. Applies trigger polarity,
//               latches edges into a pending bit, handles claim and software
//               clear/set, and flushes state whenever the trigger mode changes.
//               o_pend is the effective pending value for the next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module clic_gateway
    import clic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ip,
    input  logic [1:0] i_trig,
    input  logic       i_sw_we,
    input  logic       i_sw_wd,
    input  logic       i_claim,
    output logic       o_pend
);

    trig_e w_trig;
    logic  w_pol;
    logic  w_edge_mode;
    logic  w_trig_chg;
    logic  w_set;
    logic  w_clr;
    logic  w_pend_next;

    logic       r_pol_prev;
    logic       r_pend;
    logic [1:0] r_trig;

    assign w_trig      = trig_e'(i_trig);
    assign w_pol       = i_ip ^ i_trig[1];
    assign w_edge_mode = (w_trig == POS_EDGE) || (w_trig == NEG_EDGE);
    assign w_trig_chg  = (i_trig != r_trig);

    // A new edge or a software write of 1 always beats any clear
    assign w_set = (w_pol & ~r_pol_prev) | (i_sw_we & i_sw_wd);
    assign w_clr = i_claim | (i_sw_we & ~i_sw_wd);

    // Next edge-pending state; level mode and mode changes keep it empty
    always_comb begin
        w_pend_next = 1'b0;
        if (!w_trig_chg && w_edge_mode) begin
            w_pend_next = w_set | (r_pend & ~w_clr);
        end
    end

    assign o_pend = w_edge_mode ? w_pend_next : w_pol;

    // Edge history always tracks the current polarity so held lines never fire
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pol_prev <= w_pol;
            r_trig     <= i_trig;
        end else begin
            r_pend     <= w_pend_next;
            r_pol_prev <= w_pol;
            r_trig     <= i_trig;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clic_gateway_adapter.sv
`default_nettype none
// ============================================================================
// Module      : clic_gateway_adapter
// Description : Registers CLIC per-source configuration, VS mapping and VS
//               priorities for the arbiter, runs one gateway per source and
//               services the core's claim handshake with pending write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module clic_gateway_adapter
    import clic_pkg::*;
#(
    parameter int N_SOURCE     = 32,
    parameter int INTCTLBITS   = 8,
    parameter int VsidWidth    = 6,
    parameter int VsprioWidth  = 8,
    parameter int N_VSCTXTS    = 16,
    parameter int SRC_PER_WORD = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  clicint_reg2hw_t              clicint_reg2hw  [N_SOURCE],
    output clicint_hw2reg_t              clicint_hw2reg  [N_SOURCE],
    input  clicintv_reg2hw_t             clicintv_reg2hw [ceildiv(N_SOURCE, SRC_PER_WORD)],
    input  clicvs_reg2hw_t               clicvs_reg2hw   [N_VSCTXTS/4],
    input  logic [N_SOURCE-1:0]          ip_i,
    input  logic                         claim_valid_i,
    input  logic [$clog2(N_SOURCE)-1:0]  claim_id_i,
    output logic                         claim_ack_o,
    output logic [7:0]                   intctl_o        [N_SOURCE],
    output logic [1:0]                   intmode_o       [N_SOURCE],
    output logic [VsidWidth-1:0]         vsid_o          [N_SOURCE],
    output logic [N_SOURCE-1:0]          intv_o,
    output logic [VsprioWidth-1:0]       vsprio_o        [N_VSCTXTS],
    output logic [N_SOURCE-1:0]          shv_o,
    output logic [N_SOURCE-1:0]          ie_o,
    output logic [N_SOURCE-1:0]          ip_o,
    output logic [N_SOURCE-1:0]          le_o
);

    localparam int         c_id_w         = $clog2(N_SOURCE);
    localparam int         c_n_intv_words = ceildiv(N_SOURCE, SRC_PER_WORD);
    localparam int         c_n_vs_words   = N_VSCTXTS / 4;
    localparam bit         c_params_ok    = params_legal(N_SOURCE, INTCTLBITS, VsidWidth,
                                                         VsprioWidth, N_VSCTXTS, SRC_PER_WORD);
    // Unimplemented clicintctl LSBs read as ones
    localparam logic [7:0] c_intctl_pad   = 8'((9'd1 << (8 - INTCTLBITS)) - 9'd1);

    if (!c_params_ok) begin : g_param_check
        $error("clic_gateway_adapter: illegal parameter combination");
    end

    logic [N_SOURCE-1:0]    w_pend;
    logic [N_SOURCE-1:0]    w_ip_next;
    logic [N_SOURCE-1:0]    w_claim_hit;
    logic [VsidWidth-1:0]   w_vsid   [N_SOURCE];
    logic [N_SOURCE-1:0]    w_intv;
    logic [VsprioWidth-1:0] w_vsprio [N_VSCTXTS];
    logic                   w_unused_cfg;

    // Per-source gateway, claim decode, VS mapping and write-back
    for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
        localparam int c_word = i / SRC_PER_WORD;
        localparam int c_fld  = i % SRC_PER_WORD;

        assign w_claim_hit[i] = claim_valid_i && (claim_id_i == c_id_w'(i));
        assign w_vsid[i]      = clicintv_reg2hw[c_word].fld[c_fld].vsid[VsidWidth-1:0];
        assign w_intv[i]      = clicintv_reg2hw[c_word].fld[c_fld].v;

        clic_gateway u_gateway (
            .clk     (clk_i),
            .rst     (rst_i),
            .i_ip    (ip_i[i]),
            .i_trig  (clicint_reg2hw[i].attr.trig),
            .i_sw_we (clicint_reg2hw[i].ip.qe),
            .i_sw_wd (clicint_reg2hw[i].ip.q),
            .i_claim (w_claim_hit[i]),
            .o_pend  (w_pend[i])
        );

        // Only report a write-back when the visible pending bit actually moves
        assign clicint_hw2reg[i] = clicint_hw2reg_t'({w_ip_next[i], w_ip_next[i] != ip_o[i]});
    end

    for (genvar j = 0; j < N_VSCTXTS; j++) begin : g_vs
        assign w_vsprio[j] = clicvs_reg2hw[j / 4].prio[j % 4][VsprioWidth-1:0];
    end

    assign w_ip_next = rst_i ? '0 : w_pend;

    // Fold in register-file bits that the chosen widths/packing leave unused
    always_comb begin
        w_unused_cfg = 1'b0;
        for (int w = 0; w < c_n_intv_words; w++) begin
            w_unused_cfg = w_unused_cfg ^ (^clicintv_reg2hw[w]);
        end
        for (int k = 0; k < c_n_vs_words; k++) begin
            w_unused_cfg = w_unused_cfg ^ (^clicvs_reg2hw[k]);
        end
    end

    // Registered configuration, pending and claim acknowledge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            claim_ack_o <= 1'b0;
            ip_o        <= '0;
            ie_o        <= '0;
            shv_o       <= '0;
            le_o        <= '0;
            intv_o      <= '0;
            for (int i = 0; i < N_SOURCE; i++) begin
                intctl_o[i]  <= c_intctl_pad;
                intmode_o[i] <= '0;
                vsid_o[i]    <= '0;
            end
            for (int j = 0; j < N_VSCTXTS; j++) begin
                vsprio_o[j] <= '0;
            end
        end else begin
            claim_ack_o <= claim_valid_i;
            ip_o        <= w_ip_next;
            intv_o      <= w_intv;
            for (int i = 0; i < N_SOURCE; i++) begin
                intctl_o[i]  <= clicint_reg2hw[i].ctl.q | c_intctl_pad;
                intmode_o[i] <= clicint_reg2hw[i].attr.mode;
                vsid_o[i]    <= w_vsid[i];
                ie_o[i]      <= clicint_reg2hw[i].ie.q;
                shv_o[i]     <= clicint_reg2hw[i].attr.shv;
                le_o[i]      <= clicint_reg2hw[i].attr.trig[0];
            end
            for (int j = 0; j < N_VSCTXTS; j++) begin
                vsprio_o[j] <= w_vsprio[j];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clic_gateway_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clic_gateway_adapter
// Description : Self-checking bench: a behavioural pending/config model for a
//               32-source adapter compared every cycle, directed scenarios
//               with literal expectations, and a small 6-source instance for
//               packing, padding and out-of-range claims.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clic_gateway_adapter;
    import clic_pkg::*;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- instance A: default parameters ----------------
    clicint_reg2hw_t  a_int  [32];
    clicint_hw2reg_t  a_hw   [32];
    clicintv_reg2hw_t a_intv [8];
    clicvs_reg2hw_t   a_vs   [4];
    logic [31:0]      a_ip;
    logic             a_cv;
    logic [4:0]       a_cid;
    logic             a_ack;
    logic [7:0]       a_intctl  [32];
    logic [1:0]       a_intmode [32];
    logic [5:0]       a_vsid    [32];
    logic [31:0]      a_intv_o;
    logic [7:0]       a_vsprio  [16];
    logic [31:0]      a_shv, a_ie, a_ipo, a_le;

    clic_gateway_adapter u_dut_a (
        .clk_i           (clk),
        .rst_i           (rst),
        .clicint_reg2hw  (a_int),
        .clicint_hw2reg  (a_hw),
        .clicintv_reg2hw (a_intv),
        .clicvs_reg2hw   (a_vs),
        .ip_i            (a_ip),
        .claim_valid_i   (a_cv),
        .claim_id_i      (a_cid),
        .claim_ack_o     (a_ack),
        .intctl_o        (a_intctl),
        .intmode_o       (a_intmode),
        .vsid_o          (a_vsid),
        .intv_o          (a_intv_o),
        .vsprio_o        (a_vsprio),
        .shv_o           (a_shv),
        .ie_o            (a_ie),
        .ip_o            (a_ipo),
        .le_o            (a_le)
    );

    // ---------------- instance B: 6 sources, 3 ctl bits ----------------
    clicint_reg2hw_t  b_int  [6];
    clicint_hw2reg_t  b_hw   [6];
    clicintv_reg2hw_t b_intv [2];
    clicvs_reg2hw_t   b_vs   [1];
    logic [5:0]       b_ip;
    logic             b_cv;
    logic [2:0]       b_cid;
    logic             b_ack;
    logic [7:0]       b_intctl  [6];
    logic [1:0]       b_intmode [6];
    logic [5:0]       b_vsid    [6];
    logic [5:0]       b_intv_o;
    logic [7:0]       b_vsprio  [4];
    logic [5:0]       b_shv, b_ie, b_ipo, b_le;

    clic_gateway_adapter #(
        .N_SOURCE     (6),
        .INTCTLBITS   (3),
        .VsidWidth    (6),
        .VsprioWidth  (8),
        .N_VSCTXTS    (4),
        .SRC_PER_WORD (4)
    ) u_dut_b (
        .clk_i           (clk),
        .rst_i           (rst),
        .clicint_reg2hw  (b_int),
        .clicint_hw2reg  (b_hw),
        .clicintv_reg2hw (b_intv),
        .clicvs_reg2hw   (b_vs),
        .ip_i            (b_ip),
        .claim_valid_i   (b_cv),
        .claim_id_i      (b_cid),
        .claim_ack_o     (b_ack),
        .intctl_o        (b_intctl),
        .intmode_o       (b_intmode),
        .vsid_o          (b_vsid),
        .intv_o          (b_intv_o),
        .vsprio_o        (b_vsprio),
        .shv_o           (b_shv),
        .ie_o            (b_ie),
        .ip_o            (b_ipo),
        .le_o            (b_le)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model for instance A ----------------
    bit          m_valid = 1'b0;
    logic [31:0] m_ip, m_nxt, m_le, m_ie, m_shv, m_intv;
    logic        m_ack;
    logic        m_pend [32];
    logic        m_prev [32];
    logic [1:0]  m_trig [32];
    logic [7:0]  m_intctl  [32];
    logic [1:0]  m_intmode [32];
    logic [5:0]  m_vsid    [32];
    logic [7:0]  m_vsprio  [16];
    logic [255:0] v_act, v_exp;
    logic [31:0]  v_d, v_de;

    // Inputs are stable from negedge to the next posedge: compare the current
    // registered outputs, then predict what the next posedge must produce.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ip_o", 256'(a_ipo), 256'(m_ip));
            chk("claim_ack", 256'(a_ack), 256'(m_ack));
            chk("le_o", 256'(a_le), 256'(m_le));
            chk("ie_o", 256'(a_ie), 256'(m_ie));
            chk("shv_o", 256'(a_shv), 256'(m_shv));
            chk("intv_o", 256'(a_intv_o), 256'(m_intv));
            v_act = '0; v_exp = '0;
            for (int i = 0; i < 32; i++) begin
                v_act[i*8 +: 8] = a_intctl[i];
                v_exp[i*8 +: 8] = m_intctl[i];
            end
            chk("intctl_o", v_act, v_exp);
            v_act = '0; v_exp = '0;
            for (int i = 0; i < 32; i++) begin
                v_act[i*6 +: 6] = a_vsid[i];
                v_exp[i*6 +: 6] = m_vsid[i];
                v_act[200 + i] = a_intmode[i][0];
                v_exp[200 + i] = m_intmode[i][0];
                v_act[232 + (i % 16)] = v_act[232 + (i % 16)] ^ a_intmode[i][1];
                v_exp[232 + (i % 16)] = v_exp[232 + (i % 16)] ^ m_intmode[i][1];
            end
            chk("vsid_intmode", v_act, v_exp);
            v_act = '0; v_exp = '0;
            for (int j = 0; j < 16; j++) begin
                v_act[j*8 +: 8] = a_vsprio[j];
                v_exp[j*8 +: 8] = m_vsprio[j];
            end
            chk("vsprio_o", v_act, v_exp);
        end

        m_ack = rst ? 1'b0 : a_cv;
        for (int i = 0; i < 32; i++) begin
            logic [1:0] t;
            logic       pol;
            logic       hit;
            t   = a_int[i].attr.trig;
            pol = a_ip[i] ^ t[1];
            hit = a_cv && (int'(a_cid) == i);
            if (rst) begin
                m_pend[i] = 1'b0;
                m_nxt[i]  = 1'b0;
            end else if (t != m_trig[i]) begin
                m_pend[i] = 1'b0;
                m_nxt[i]  = t[0] ? 1'b0 : pol;
            end else if (t[0]) begin
                if ((pol && !m_prev[i]) || (a_int[i].ip.qe && a_int[i].ip.q))
                    m_pend[i] = 1'b1;
                else if (hit || (a_int[i].ip.qe && !a_int[i].ip.q))
                    m_pend[i] = 1'b0;
                m_nxt[i] = m_pend[i];
            end else begin
                m_pend[i] = 1'b0;
                m_nxt[i]  = pol;
            end
            m_prev[i] = pol;
            m_trig[i] = t;

            m_intctl[i]  = rst ? 8'h00 : a_int[i].ctl.q;
            m_intmode[i] = rst ? 2'b00 : a_int[i].attr.mode;
            m_vsid[i]    = rst ? 6'd0  : a_intv[i / 4].fld[i % 4].vsid[5:0];
            m_intv[i]    = rst ? 1'b0  : a_intv[i / 4].fld[i % 4].v;
            m_le[i]      = rst ? 1'b0  : t[0];
            m_ie[i]      = rst ? 1'b0  : a_int[i].ie.q;
            m_shv[i]     = rst ? 1'b0  : a_int[i].attr.shv;
        end
        for (int j = 0; j < 16; j++) begin
            m_vsprio[j] = rst ? 8'h00 : a_vs[j / 4].prio[j % 4];
        end

        if (m_valid && !rst) begin
            for (int i = 0; i < 32; i++) begin
                v_d[i]  = a_hw[i].ip.d;
                v_de[i] = a_hw[i].ip.de;
            end
            chk("hw2reg_d", 256'(v_d), 256'(m_nxt));
            chk("hw2reg_de", 256'(v_de), 256'(m_nxt ^ m_ip));
        end
        m_ip    = m_nxt;
        m_valid = 1'b1;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        a_ip  = '0; a_cv = 1'b0; a_cid = '0;
        b_ip  = '0; b_cv = 1'b0; b_cid = '0;
        for (int i = 0; i < 32; i++) a_int[i] = '0;
        for (int i = 0; i < 8; i++)  a_intv[i] = '0;
        for (int i = 0; i < 4; i++)  a_vs[i] = '0;
        for (int i = 0; i < 6; i++)  b_int[i] = '0;
        for (int i = 0; i < 2; i++)  b_intv[i] = '0;
        b_vs[0] = '0;

        // claim presented during reset is dropped
        cyc(); cyc();
        a_cv = 1'b1; a_cid = 5'd2;
        cyc();
        chk("rst_ip_o", 256'(a_ipo), 256'(0));
        chk("rst_ack_dropped", 256'(a_ack), 256'(0));
        chk("rst_intctl_a", 256'(a_intctl[0]), 256'(8'h00));
        chk("rst_intctl_b_pad", 256'(b_intctl[0]), 256'(8'h1F));
        a_cv = 1'b0;
        rst  = 1'b0;
        cyc();

        // positive edge on source 3, then claim it
        a_int[3].attr.trig = 2'b01;
        cyc(); cyc();
        a_ip[3] = 1'b1;
        cyc();
        chk("pos_edge_ip3", 256'(a_ipo[3]), 256'(1));
        a_ip[3] = 1'b0; a_cv = 1'b1; a_cid = 5'd3;
        cyc();
        chk("claim3_ack", 256'(a_ack), 256'(1));
        chk("claim3_clear", 256'(a_ipo[3]), 256'(0));
        a_cv = 1'b0;
        cyc();
        chk("ack_one_cycle", 256'(a_ack), 256'(0));

        // negative level on source 5
        a_int[5].attr.trig = 2'b10; a_ip[5] = 1'b0;
        cyc();
        chk("neg_level_low", 256'(a_ipo[5]), 256'(1));
        a_ip[5] = 1'b1;
        cyc();
        chk("neg_level_high", 256'(a_ipo[5]), 256'(0));
        a_ip[5] = 1'b0;
        cyc();
        a_cv = 1'b1; a_cid = 5'd5;
        cyc();
        chk("claim_level_ack", 256'(a_ack), 256'(1));
        chk("claim_level_noop", 256'(a_ipo[5]), 256'(1));
        a_cv = 1'b0;

        // edge and claim in the same cycle on source 7
        a_int[7].attr.trig = 2'b01;
        cyc(); cyc();
        a_ip[7] = 1'b1; a_cv = 1'b1; a_cid = 5'd7;
        cyc();
        chk("edge_beats_claim", 256'(a_ipo[7]), 256'(1));
        a_ip[7] = 1'b0;
        a_int[7].ip.qe = 1'b1; a_int[7].ip.q = 1'b1;
        cyc();
        chk("write1_beats_claim", 256'(a_ipo[7]), 256'(1));
        a_int[7].ip.q = 1'b0;
        cyc();
        chk("write0_with_claim", 256'(a_ipo[7]), 256'(0));
        a_int[7].ip.qe = 1'b0; a_cv = 1'b0;
        cyc();

        // line held active through reset gives no edge; software set/clear
        a_int[0].attr.trig = 2'b01; a_ip[0] = 1'b1;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc(); cyc();
        chk("held_through_reset", 256'(a_ipo[0]), 256'(0));
        a_int[0].ip.qe = 1'b1; a_int[0].ip.q = 1'b1;
        cyc();
        a_int[0].ip.qe = 1'b0;
        chk("sw_write1", 256'(a_ipo[0]), 256'(1));
        a_int[0].ip.qe = 1'b1; a_int[0].ip.q = 1'b0;
        cyc();
        a_int[0].ip.qe = 1'b0;
        chk("sw_write0", 256'(a_ipo[0]), 256'(0));

        // trigger change clears a pending edge
        a_ip[3] = 1'b1;
        cyc();
        chk("edge3_again", 256'(a_ipo[3]), 256'(1));
        a_int[3].attr.trig = 2'b11;
        cyc();
        chk("trig_change_clear", 256'(a_ipo[3]), 256'(0));
        a_ip[3] = 1'b0;
        cyc();
        chk("neg_edge_ip3", 256'(a_ipo[3]), 256'(1));

        // instance B: intv packing, ctl padding, vsprio, out-of-range claim
        b_intv[1].fld[1].vsid = 8'd9; b_intv[1].fld[1].v = 1'b1;
        b_int[5].ctl.q = 8'hA0;
        b_vs[0].prio[2] = 8'h5A;
        b_int[1].attr.trig = 2'b01;
        cyc();
        chk("b_vsid5", 256'(b_vsid[5]), 256'(9));
        chk("b_intv5", 256'(b_intv_o), 256'(6'b100000));
        chk("b_intctl5", 256'(b_intctl[5]), 256'(8'hBF));
        chk("b_vsprio2", 256'(b_vsprio[2]), 256'(8'h5A));
        b_ip[1] = 1'b1;
        cyc();
        chk("b_edge1", 256'(b_ipo), 256'(6'b000010));
        b_cv = 1'b1; b_cid = 3'd7;
        cyc();
        chk("b_oor_ack", 256'(b_ack), 256'(1));
        chk("b_oor_noop", 256'(b_ipo), 256'(6'b000010));
        b_cid = 3'd1;
        cyc();
        chk("b_claim1", 256'(b_ipo), 256'(6'b000000));
        b_cv = 1'b0;

        // randomized traffic on instance A, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            int s;
            cyc();
            for (int i = 0; i < 32; i++) a_int[i].ip.qe = 1'b0;
            if ($urandom % 4 == 0) begin
                s = int'($urandom % 32);
                a_int[s].ip.qe = 1'b1;
                a_int[s].ip.q  = 1'($urandom);
            end
            a_cv  = ($urandom % 3 == 0);
            a_cid = 5'($urandom);
            a_ip  = a_ip ^ ($urandom & $urandom & $urandom);
            if ($urandom % 16 == 0) begin
                s = int'($urandom % 32);
                a_int[s].attr.trig = 2'($urandom);
            end
            if ($urandom % 8 == 0) begin
                s = int'($urandom % 32);
                a_int[s].ctl.q     = 8'($urandom);
                a_int[s].attr.mode = 2'($urandom);
                a_int[s].attr.shv  = 1'($urandom);
                a_int[s].ie.q      = 1'($urandom);
            end
            if ($urandom % 16 == 0) begin
                s = int'($urandom % 8);
                a_intv[s].fld[$urandom % 4] = clicintv_field_t'($urandom);
            end
            if ($urandom % 16 == 0) begin
                s = int'($urandom % 4);
                a_vs[s].prio[$urandom % 4] = 8'($urandom);
            end
            rst = ($urandom % 400 == 0);
        end
        cyc();
        rst = 1'b0; a_cv = 1'b0;
        for (int i = 0; i < 32; i++) a_int[i].ip.qe = 1'b0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
